xdma_clock_ctrl: RTL

//  Generates core_clock_enable for the core clock gate in the FPGA-sim XDMA path.

---
 rtl/xdma_clock_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/xdma_clock_ctrl.sv
// Core clock-enable controller for the XDMA path: run/halt/single-step on host command,
// stall on transfer-buffer backpressure. Optional macro XDMA_CLOCK_PERF_EN adds cycle counters.
module xdma_clock_ctrl #(
    parameter int CNT_W = 32,
    parameter int LVL_W = 10,
    parameter int HI_WM = 768,
    parameter int LO_WM = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             host_run,
    input  logic             host_step_valid,
    output logic             host_step_ready,
    input  logic [CNT_W-1:0] host_step_cnt,
    input  logic [LVL_W-1:0] buf_level,
    output logic             core_clock_enable,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] steps_left
`ifdef XDMA_CLOCK_PERF_EN
    ,
    output logic [63:0]      run_cycles,
    output logic [63:0]      stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    if (LO_WM >= HI_WM) begin : g_wm_check
        $error("xdma_clock_ctrl: LO_WM must be below HI_WM");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ret_step;
    logic             w_ret_step_nxt;
    logic [CNT_W-1:0] r_steps;
    logic [CNT_W-1:0] w_steps_nxt;
    logic             r_cce;
    logic             w_grant;
    logic             w_step_fire;
    logic             w_hi;
    logic             w_lo;

    assign w_grant         = (r_state == S_RUN) || (r_state == S_STEP);
    assign host_step_ready = (r_state == S_HALT);
    assign w_step_fire     = host_step_valid && host_step_ready;
    assign w_hi            = (buf_level >= LVL_W'(HI_WM));
    assign w_lo            = (buf_level <= LVL_W'(LO_WM));

    assign state_o           = r_state;
    assign steps_left        = r_steps;
    assign core_clock_enable = r_cce;

    // Next-state, return-target and step-budget decode
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_step_nxt = r_ret_step;
        w_steps_nxt    = r_steps;
        case (r_state)
            S_HALT: begin
                if (w_step_fire) begin
                    if (host_step_cnt != {CNT_W{1'b0}}) begin
                        w_state_nxt = S_STEP;
                        w_steps_nxt = host_step_cnt;
                    end else begin
                        w_state_nxt = S_HALT;
                    end
                end else if (host_run) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            S_RUN: begin
                if (!host_run) begin
                    w_state_nxt = S_HALT;
                end else if (w_hi) begin
                    w_state_nxt    = S_STALL;
                    w_ret_step_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_STEP: begin
                // The pulse granted into this edge is already out, so it is always charged.
                if (r_steps <= CNT_W'(1)) begin
                    w_state_nxt = S_HALT;
                    w_steps_nxt = {CNT_W{1'b0}};
                end else if (w_hi) begin
                    w_state_nxt    = S_STALL;
                    w_ret_step_nxt = 1'b1;
                    w_steps_nxt    = r_steps - CNT_W'(1);
                end else begin
                    w_state_nxt = S_STEP;
                    w_steps_nxt = r_steps - CNT_W'(1);
                end
            end
            S_STALL: begin
                if (w_lo) begin
                    if (r_ret_step) begin
                        w_state_nxt = S_STEP;
                    end else if (host_run) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_HALT;
                    end
                end else begin
                    w_state_nxt = S_STALL;
                end
            end
            default: begin
                w_state_nxt    = S_HALT;
                w_ret_step_nxt = 1'b0;
                w_steps_nxt    = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_HALT;
            r_ret_step <= 1'b0;
            r_steps    <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_ret_step <= w_ret_step_nxt;
            r_steps    <= w_steps_nxt;
        end
    end

    // Gate enable re-timed to the low phase so the downstream AND gate never glitches
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_cce <= 1'b0;
        end else begin
            r_cce <= w_grant;
        end
    end

`ifdef XDMA_CLOCK_PERF_EN
    logic [63:0] r_run_cycles;
    logic [63:0] r_stall_cycles;

    assign run_cycles   = r_run_cycles;
    assign stall_cycles = r_stall_cycles;

    // Saturating grant and stall cycle counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run_cycles   <= 64'd0;
            r_stall_cycles <= 64'd0;
        end else begin
            if (w_grant && (r_run_cycles != {64{1'b1}})) begin
                r_run_cycles <= r_run_cycles + 64'd1;
            end else begin
                r_run_cycles <= r_run_cycles;
            end
            if ((r_state == S_STALL) && (r_stall_cycles != {64{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 64'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
        end
    end
`endif

endmodule
